cache_access_arbiter: RTL and testbench

- Front-end controller for the 4-way set-associative L1 cache (5-bit address, 3-bit data, 9-bit way word).
- Shares the single cache port between two requesters (port 0, port 1) with round-robin arbitration.
- Sequences each access: issue, sample hit/writeBack, stall for modelled write-back and miss-fill penalties, then acknowledge.
- Sits between the requester models and the cache instance. The cache performs exactly one access on each clock edge where cacheReq=1, and no access otherwise.

---
 rtl/cache_access_arbiter.sv | 255 +++++++++++++++++++++++++
 tb/tb_cache_access_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_access_arbiter.sv
// ---------------------------------------------------------------------------
// cache_access_arbiter
//
// Front-end controller for the 4-way set-associative L1 cache. Two requesters
// share the single cache port under round-robin arbitration. Each granted
// access walks IDLE -> ISSUE -> SAMPLE -> [WB_STALL] -> [MISS_STALL] -> RESP.
// The stall states model the write-back and miss-fill penalties. RESP then
// acknowledges the owning port, and IDLE always separates two transactions.
//
// Handshake: a requester raises reqN with addrN/wdataN/weN and holds req until
// ackN. Address, data and write enable are sampled once, in the IDLE cycle
// that grants the port; later changes are ignored. ackN is a one-cycle pulse
// and rdataN is valid only while ackN=1. A req still high in the cycle after
// ack counts as a fresh request. Dropping req before ack does not cancel the
// access. The cache side is strobe-only: it performs one access on each
// clock edge where cacheReq=1 and returns hit/writeBack/word in the next
// cycle.
//
// Optional feature macro: ARB_STATS_EN (hit/miss/write-back counters).
//
// Ports:
//   clock, reset                 clock; synchronous active-high reset
//   req0/addr0/wdata0/we0        requester 0 inputs
//   ack0/rdata0                  requester 0 completion pulse and data
//   req1/addr1/wdata1/we1        requester 1 inputs
//   ack1/rdata1                  requester 1 completion pulse and data
//   cacheReq                     cache access strobe (ISSUE only)
//   cacheAddress/Write/Wren      latched access fields, 0 in IDLE
//   cacheWord/cacheHit/
//   cacheWriteBack               cache response, sampled in SAMPLE
//   busy                         state != IDLE
//   hitCount/missCount/wbCount   saturating statistics (0 without macro)
//   dbgState                     current FSM state encoding
// ---------------------------------------------------------------------------
module cache_access_arbiter #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 3,
  parameter int WORD_W      = 9,
  parameter int WB_CYCLES   = 4,
  parameter int MISS_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              cacheReq,
  output logic [ADDR_W-1:0] cacheAddress,
  output logic [DATA_W-1:0] cacheWrite,
  output logic              cacheWren,
  input  logic [WORD_W-1:0] cacheWord,
  input  logic              cacheHit,
  input  logic              cacheWriteBack,
  output logic              busy,
  output logic [7:0]        hitCount,
  output logic [7:0]        missCount,
  output logic [7:0]        wbCount,
  output logic [2:0]        dbgState
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    SAMPLE     = 3'd2,
    WB_STALL   = 3'd3,
    MISS_STALL = 3'd4,
    RESP       = 3'd5
  } state_e;

  localparam logic [3:0] WB_LOAD   = 4'(WB_CYCLES);
  localparam logic [3:0] MISS_LOAD = 4'(MISS_CYCLES);

  state_e            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;   // port that wins the next tie
  logic              owner_q, owner_d;     // 1 = port 1 owns the transaction
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [3:0]        cnt_q, cnt_d;         // stall counter
  logic              hit_q, hit_d;         // captured cacheHit
  logic              wb_q, wb_d;           // captured cacheWriteBack
  logic [DATA_W-1:0] data_q, data_d;       // captured cacheWord data field
  logic              grant1;

  // Only the data field of the way word is returned to the requesters.
  logic unused_word;
  assign unused_word = ^cacheWord[WORD_W-1:DATA_W];

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
      wb_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      wb_q     <= wb_d;
      data_q   <= data_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;
    wb_d     = wb_q;
    data_d   = data_q;
    grant1   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // A single requester always wins; a tie goes to rr_ptr.
          grant1  = (req0 && req1) ? rr_ptr_q : req1;
          owner_d = grant1;
          addr_d  = grant1 ? addr1  : addr0;
          wdata_d = grant1 ? wdata1 : wdata0;
          we_d    = grant1 ? we1    : we0;
          state_d = ISSUE;
        end
      end

      ISSUE: state_d = SAMPLE;

      SAMPLE: begin
        hit_d  = cacheHit;
        wb_d   = cacheWriteBack;
        data_d = cacheWord[DATA_W-1:0];
        if (cacheWriteBack) begin
          cnt_d   = WB_LOAD;
          state_d = WB_STALL;
        end else if (!cacheHit) begin
          cnt_d   = MISS_LOAD;
          state_d = MISS_STALL;
        end else begin
          state_d = RESP;
        end
      end

      // Counter value 1 marks the last stall cycle, so each stall state
      // lasts exactly its load value in cycles.
      WB_STALL: begin
        if (cnt_q == 4'd1) begin
          if (!hit_q) begin
            cnt_d   = MISS_LOAD;
            state_d = MISS_STALL;
          end else begin
            // Dirty write hit: eviction paid, no fill needed.
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      MISS_STALL: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RESP: begin
        rr_ptr_d = ~owner_q;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs, decoded from registered state
  // -------------------------------------------------------------------------
  assign busy         = (state_q != IDLE);
  assign cacheReq     = (state_q == ISSUE);
  assign cacheAddress = busy ? addr_q  : '0;
  assign cacheWrite   = busy ? wdata_q : '0;
  assign cacheWren    = busy ? we_q    : 1'b0;

  assign ack0   = (state_q == RESP) && !owner_q;
  assign ack1   = (state_q == RESP) &&  owner_q;
  assign rdata0 = ack0 ? data_q : '0;
  assign rdata1 = ack1 ? data_q : '0;

  assign dbgState = state_q;

  // -------------------------------------------------------------------------
  // Statistics
  // -------------------------------------------------------------------------
`ifdef ARB_STATS_EN
  logic [7:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else if (state_q == SAMPLE) begin
      if (cacheHit && (hit_cnt_q != 8'hFF)) begin
        hit_cnt_q <= hit_cnt_q + 8'd1;
      end
      if (!cacheHit && (miss_cnt_q != 8'hFF)) begin
        miss_cnt_q <= miss_cnt_q + 8'd1;
      end
      if (cacheWriteBack && (wb_cnt_q != 8'hFF)) begin
        wb_cnt_q <= wb_cnt_q + 8'd1;
      end
    end
  end

  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;
  assign wbCount   = wb_cnt_q;
`else
  assign hitCount  = 8'd0;
  assign missCount = 8'd0;
  assign wbCount   = 8'd0;
`endif

endmodule

// File: tb/tb_cache_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_access_arbiter
//
// Self-checking bench for cache_access_arbiter. The requesters and the cache
// response are driven from tasks. Expected acks are queued as
// {port, rdata, latency} when a transaction is launched and popped when the
// DUT acknowledges. Latency is counted in cycles from the IDLE cycle that
// sees the request.
// ---------------------------------------------------------------------------
module tb_cache_access_arbiter;

  localparam int ADDR_W      = 5;
  localparam int DATA_W      = 3;
  localparam int WORD_W      = 9;
  localparam int WB_CYCLES   = 4;
  localparam int MISS_CYCLES = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_WB     = 3'd3;
  localparam logic [2:0] ST_MISS   = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

  // ---------------------------------------------------------------- clock/reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic              req0, we0, ack0, req1, we1, ack1;
  logic [ADDR_W-1:0] addr0, addr1, cacheAddress;
  logic [DATA_W-1:0] wdata0, wdata1, rdata0, rdata1, cacheWrite;
  logic              cacheReq, cacheWren, cacheHit, cacheWriteBack, busy;
  logic [WORD_W-1:0] cacheWord;
  logic [7:0]        hitCount, missCount, wbCount;
  logic [2:0]        dbgState;

  cache_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORD_W(WORD_W),
    .WB_CYCLES(WB_CYCLES), .MISS_CYCLES(MISS_CYCLES)
  ) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1),
    .ack1(ack1), .rdata1(rdata1),
    .cacheReq(cacheReq), .cacheAddress(cacheAddress),
    .cacheWrite(cacheWrite), .cacheWren(cacheWren),
    .cacheWord(cacheWord), .cacheHit(cacheHit),
    .cacheWriteBack(cacheWriteBack), .busy(busy),
    .hitCount(hitCount), .missCount(missCount), .wbCount(wbCount),
    .dbgState(dbgState)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_cmp  = 0;
  int n_fail = 0;
  logic [11:0] exp_q[$];            // {port, rdata[2:0], latency[7:0]}
  logic [2:0]  trace [0:31];
  logic [ADDR_W-1:0] iss_addr, ack_addr;
  logic [DATA_W-1:0] iss_wdata;
  logic              iss_we, ack_we;

  function automatic logic [11:0] pop_exp();
    if (exp_q.size() == 0) return 12'hFFF;
    return exp_q.pop_front();
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic apply_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic drive_req(input int port, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] wd, input logic we);
    if (port == 0) begin
      req0 = 1'b1; addr0 = a; wdata0 = wd; we0 = we;
    end else begin
      req1 = 1'b1; addr1 = a; wdata1 = wd; we1 = we;
    end
  endtask

  task automatic set_cache(input logic hit, input logic wb, input logic [WORD_W-1:0] word);
    cacheHit = hit; cacheWriteBack = wb; cacheWord = word;
  endtask

  // Watches up to 'budget' cycles for an ack. got = {ack1, rdata, cycle};
  // all zero on timeout. stray counts double acks or rdata outside an ack.
  task automatic observe_txn(input int budget, output logic [11:0] got,
                             output int nreq, output int stray);
    got = '0; nreq = 0; stray = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clock);
      if (k < 32) trace[k] = dbgState;
      if (cacheReq) begin
        nreq++;
        iss_addr = cacheAddress; iss_wdata = cacheWrite; iss_we = cacheWren;
      end
      if (ack0 || ack1) begin
        got = {ack1, (ack1 ? rdata1 : rdata0), 8'(k)};
        if (ack0 && ack1) stray++;
        if ((ack0 && rdata1 != '0) || (ack1 && rdata0 != '0)) stray++;
        ack_addr = cacheAddress; ack_we = cacheWren;
        break;
      end else if (rdata0 != '0 || rdata1 != '0) begin
        stray++;
      end
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    apply_reset();
    n_cmp++; if (dbgState !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbgState, ST_IDLE); end
    n_cmp++; if ({busy, cacheReq, ack0, ack1} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {busy, cacheReq, ack0, ack1}); end
    n_cmp++; if ({cacheAddress, cacheWrite, cacheWren, rdata0, rdata1} !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {cacheAddress, cacheWrite, cacheWren, rdata0, rdata1}); end
    n_cmp++; if ({hitCount, missCount, wbCount} !== 24'd0) begin n_fail++; $display("FAIL reset_stats: got %h want 0", {hitCount, missCount, wbCount}); end
  endtask

  task automatic test_hit_read();
    logic [11:0] got, exp; int nreq, stray;
    set_cache(1'b1, 1'b0, 9'b110001001);
    exp_q.push_back({1'b0, 3'b001, 8'd3});
    drive_req(0, 5'b00100, 3'b000, 1'b0);
    observe_txn(20, got, nreq, stray);
    req0 = 1'b0;
    exp = pop_exp();
    n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL hit_read_ack: got %h want %h", got, exp); end
    n_cmp++; if (nreq !== 1 || trace[1] !== ST_ISSUE) begin n_fail++; $display("FAIL hit_read_strobe: got %0d/%0d want 1/%0d", nreq, trace[1], ST_ISSUE); end
    n_cmp++; if ({iss_addr, iss_we} !== {5'b00100, 1'b0}) begin n_fail++; $display("FAIL hit_read_issue: got %h want %h", {iss_addr, iss_we}, {5'b00100, 1'b0}); end
    n_cmp++; if (stray !== 0) begin n_fail++; $display("FAIL hit_read_other_port: got %0d want 0", stray); end
    @(negedge clock);
    n_cmp++; if ({busy, cacheAddress} !== '0) begin n_fail++; $display("FAIL hit_read_idle_out: got %h want 0", {busy, cacheAddress}); end
  endtask

  task automatic test_miss_read();
    logic [11:0] got, exp; int nreq, stray;
    set_cache(1'b0, 1'b0, 9'b110010010);
    exp_q.push_back({1'b1, 3'b010, 8'(3 + MISS_CYCLES)});
    drive_req(1, 5'b01101, 3'b000, 1'b0);
    observe_txn(20, got, nreq, stray);
    req1 = 1'b0;
    exp = pop_exp();
    n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL miss_read_ack: got %h want %h", got, exp); end
    n_cmp++; if (iss_addr !== 5'b01101 || nreq !== 1 || stray !== 0) begin n_fail++; $display("FAIL miss_read_issue: got %h/%0d/%0d want 0d/1/0", iss_addr, nreq, stray); end
    @(negedge clock);
  endtask

  task automatic test_wb_miss_write();
    logic [11:0] got, exp; int nreq, stray; logic [2:0] want;
    set_cache(1'b0, 1'b1, 9'b111011111);
    exp_q.push_back({1'b0, 3'b111, 8'(3 + WB_CYCLES + MISS_CYCLES)});
    drive_req(0, 5'b10011, 3'b111, 1'b1);
    observe_txn(30, got, nreq, stray);
    req0 = 1'b0;
    exp = pop_exp();
    n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL wb_miss_ack: got %h want %h", got, exp); end
    n_cmp++; if ({iss_addr, iss_wdata, iss_we} !== {5'b10011, 3'b111, 1'b1}) begin n_fail++; $display("FAIL wb_miss_issue: got %h want %h", {iss_addr, iss_wdata, iss_we}, {5'b10011, 3'b111, 1'b1}); end
    for (int k = 1; k <= 3 + WB_CYCLES + MISS_CYCLES; k++) begin
      if (k == 1) want = ST_ISSUE;
      else if (k == 2) want = ST_SAMPLE;
      else if (k <= 2 + WB_CYCLES) want = ST_WB;
      else if (k <= 2 + WB_CYCLES + MISS_CYCLES) want = ST_MISS;
      else want = ST_RESP;
      n_cmp++; if (trace[k] !== want) begin n_fail++; $display("FAIL wb_miss_state_c%0d: got %0d want %0d", k, trace[k], want); end
    end
    @(negedge clock);
  endtask

  task automatic test_dirty_write_hit();
    logic [11:0] got, exp; int nreq, stray;
    set_cache(1'b1, 1'b1, 9'b111011010);
    exp_q.push_back({1'b1, 3'b010, 8'(3 + WB_CYCLES)});
    drive_req(1, 5'b11110, 3'b010, 1'b1);
    observe_txn(30, got, nreq, stray);
    req1 = 1'b0;
    exp = pop_exp();
    n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL dirty_hit_ack: got %h want %h", got, exp); end
    n_cmp++; if (trace[3 + WB_CYCLES - 1] !== ST_WB) begin n_fail++; $display("FAIL dirty_hit_state: got %0d want %0d", trace[3 + WB_CYCLES - 1], ST_WB); end
    @(negedge clock);
  endtask

  task automatic test_req_drop();
    logic [11:0] got, exp; int nreq, stray;
    set_cache(1'b0, 1'b0, 9'b100000101);
    exp_q.push_back({1'b0, 3'b101, 8'(3 + MISS_CYCLES - 1)});
    drive_req(0, 5'b10110, 3'b000, 1'b0);
    @(negedge clock);
    n_cmp++; if ({cacheReq, cacheAddress} !== {1'b1, 5'b10110}) begin n_fail++; $display("FAIL drop_issue: got %h want %h", {cacheReq, cacheAddress}, {1'b1, 5'b10110}); end
    // Requester gives up and scribbles over its fields after the grant.
    req0 = 1'b0; addr0 = 5'b00001; wdata0 = 3'b110; we0 = 1'b1;
    observe_txn(20, got, nreq, stray);
    exp = pop_exp();
    n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL drop_ack: got %h want %h", got, exp); end
    n_cmp++; if ({ack_addr, ack_we} !== {5'b10110, 1'b0}) begin n_fail++; $display("FAIL drop_latched: got %h want %h", {ack_addr, ack_we}, {5'b10110, 1'b0}); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    logic [11:0] got, exp; int nreq, stray;
    apply_reset();
    set_cache(1'b1, 1'b0, 9'b110001001);
    exp_q.push_back({1'b0, 3'b001, 8'd3});
    exp_q.push_back({1'b1, 3'b001, 8'd4});
    exp_q.push_back({1'b0, 3'b001, 8'd4});
    exp_q.push_back({1'b1, 3'b001, 8'd4});
    drive_req(0, 5'b00010, 3'b000, 1'b0);
    drive_req(1, 5'b00011, 3'b000, 1'b0);
    for (int t = 0; t < 4; t++) begin
      observe_txn(20, got, nreq, stray);
      exp = pop_exp();
      n_cmp++; if (got !== exp || nreq !== 1) begin n_fail++; $display("FAIL b2b_ack%0d: got %h/%0d want %h/1", t, got, nreq, exp); end
      n_cmp++; if (iss_addr !== (got[11] ? 5'b00011 : 5'b00010)) begin n_fail++; $display("FAIL b2b_addr%0d: got %h", t, iss_addr); end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    logic [11:0] got, exp; int nreq, stray, acks;
    // Complete one port 0 access so the round-robin pointer favours port 1.
    set_cache(1'b1, 1'b0, 9'b110001001);
    exp_q.push_back({1'b0, 3'b001, 8'd3});
    drive_req(0, 5'b00100, 3'b000, 1'b0);
    observe_txn(20, got, nreq, stray);
    req0 = 1'b0;
    exp = pop_exp();
    n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL rst_mid_pre: got %h want %h", got, exp); end
    @(negedge clock);
    set_cache(1'b0, 1'b1, 9'b111011111);
    drive_req(0, 5'b01000, 3'b111, 1'b1);
    repeat (4) @(negedge clock);
    n_cmp++; if (dbgState !== ST_WB) begin n_fail++; $display("FAIL rst_mid_in_wb: got %0d want %0d", dbgState, ST_WB); end
    reset = 1'b1; req0 = 1'b0;
    @(negedge clock);
    n_cmp++; if ({dbgState, busy, ack0, ack1} !== {ST_IDLE, 3'b000}) begin n_fail++; $display("FAIL rst_mid_idle: got %h want %h", {dbgState, busy, ack0, ack1}, {ST_IDLE, 3'b000}); end
    reset = 1'b0;
    acks = 0;
    repeat (10) begin
      @(negedge clock);
      if (ack0 || ack1 || busy) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL rst_mid_no_ack: got %0d want 0", acks); end
    // After reset a tie goes to port 0 again, then port 1.
    set_cache(1'b1, 1'b0, 9'b110001011);
    exp_q.push_back({1'b0, 3'b011, 8'd3});
    exp_q.push_back({1'b1, 3'b011, 8'd4});
    drive_req(0, 5'b00101, 3'b000, 1'b0);
    drive_req(1, 5'b00110, 3'b000, 1'b0);
    observe_txn(20, got, nreq, stray);
    req0 = 1'b0;
    exp = pop_exp();
    n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL rst_mid_tie: got %h want %h", got, exp); end
    observe_txn(20, got, nreq, stray);
    req1 = 1'b0;
    exp = pop_exp();
    n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL rst_mid_second: got %h want %h", got, exp); end
    @(negedge clock);
  endtask

  task automatic test_stats();
    logic [11:0] got, exp; int nreq, stray, lat, bad;
    logic [4:0] t_hit = 5'b00111;
    logic [4:0] t_wb  = 5'b10000;
    logic [2:0] d;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      d = 3'(i + 1);
      set_cache(t_hit[i], t_wb[i], {6'b110000, d});
      lat = 3 + (t_wb[i] ? WB_CYCLES : 0) + (t_hit[i] ? 0 : MISS_CYCLES);
      exp_q.push_back({1'b0, d, 8'(lat)});
      drive_req(0, 5'(i), 3'b000, 1'b0);
      observe_txn(30, got, nreq, stray);
      req0 = 1'b0;
      exp = pop_exp();
      n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL stats_txn%0d: got %h want %h", i, got, exp); end
      @(negedge clock);
    end
`ifdef ARB_STATS_EN
    n_cmp++; if ({hitCount, missCount, wbCount} !== {8'd3, 8'd2, 8'd1}) begin n_fail++; $display("FAIL stats_counts: got %h want 030201", {hitCount, missCount, wbCount}); end
`else
    n_cmp++; if ({hitCount, missCount, wbCount} !== 24'd0) begin n_fail++; $display("FAIL stats_counts_off: got %h want 0", {hitCount, missCount, wbCount}); end
`endif
    set_cache(1'b1, 1'b0, 9'b110001100);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back({1'b1, 3'b100, 8'd3});
      drive_req(1, 5'($urandom_range(0, 31)), 3'b000, 1'b0);
      observe_txn(20, got, nreq, stray);
      req1 = 1'b0;
      exp = pop_exp();
      if (got !== exp) bad++;
      @(negedge clock);
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL stats_hit_run: got %0d bad acks want 0", bad); end
`ifdef ARB_STATS_EN
    n_cmp++; if ({hitCount, missCount, wbCount} !== {8'd255, 8'd2, 8'd1}) begin n_fail++; $display("FAIL stats_saturate: got %h want ff0201", {hitCount, missCount, wbCount}); end
`else
    n_cmp++; if ({hitCount, missCount, wbCount} !== 24'd0) begin n_fail++; $display("FAIL stats_saturate_off: got %h want 0", {hitCount, missCount, wbCount}); end
`endif
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    reset = 1'b1;
    req0 = 1'b0; addr0 = '0; wdata0 = '0; we0 = 1'b0;
    req1 = 1'b0; addr1 = '0; wdata1 = '0; we1 = 1'b0;
    set_cache(1'b0, 1'b0, '0);
    test_reset();
    test_hit_read();
    test_miss_read();
    test_wb_miss_write();
    test_dirty_write_hit();
    test_req_drop();
    test_back_to_back();
    test_reset_mid();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
